// File: rtl/dmem_responder.sv
// Word-addressed data memory with LATENCY wait states and a ready/valid completion handshake.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic        ready,
  output logic        valid,
  output logic [31:0] DataOut,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_ready;
  logic            r_valid;
  logic [31:0]     r_dout;
  logic            r_err;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_wr;
  logic            r_rd;
  logic            r_mis;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_mis;
  logic            w_done;
  logic [AW-1:0]   w_idx;
  logic            w_unused_addr;

  assign w_accept      = (MemWr | MemRd) & r_ready;
  assign w_done        = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_idx         = Addr[AW+1:2];
  assign w_unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = (Addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  // Control FSM, request capture and read/completion data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_dout  <= 32'd0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_wdata <= DataIn;
        r_wr    <= MemWr;
        r_rd    <= MemRd;
        r_mis   <= w_mis;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          r_err <= 1'b0;
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= 4'(LATENCY);
            r_ready <= 1'b0;
            r_valid <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
            r_err   <= r_mis;
            // Read-before-write: the old word is sampled on the same edge as the write.
            if (r_mis) begin
              r_dout <= 32'd0;
            end else if (r_rd) begin
              r_dout <= r_mem[r_idx];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; a write still pending when reset hits never reaches it.
  always_ff @(posedge clk) begin
    if (rst_n && w_done && r_wr && !r_mis) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ready   = r_ready;
  assign valid   = r_valid;
  assign DataOut = r_dout;
  assign err     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected completions, a monitor pops on valid.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        MemWr;
  logic        MemRd;
  logic        ready;
  logic        valid;
  logic [31:0] DataOut;
  logic        err;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .MemWr   (MemWr),
    .MemRd   (MemRd),
    .ready   (ready),
    .valid   (valid),
    .DataOut (DataOut),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        chk("valid_not_consecutive", 32'(prev_valid), 32'd0);
        chk("ready_during_valid", 32'(ready), 32'd1);
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got valid=1 expected no completion at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("completion_cycle", 32'(cyc), 32'(e.cyc));
          chk("err", 32'(err), 32'(e.err));
          if (e.chk_data) chk("DataOut", DataOut, e.data);
        end
      end
      prev_valid = rst_n && valid;
    end
  end

  // Wait for ready at a negedge, drive a request, push its expectation, return after the accept edge.
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input bit chk_data, input logic [31:0] exp_data, input bit exp_err);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 40 cycles");
    end else begin
      Addr   = a;
      DataIn = d;
      MemWr  = wr;
      MemRd  = rd;
      e.data     = exp_data;
      e.chk_data = chk_data;
      e.err      = exp_err;
      e.cyc      = cyc + int'(LAT) + 2;
      q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    MemWr = 1'b0;
    MemRd = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic single(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input bit chk_data, input logic [31:0] exp_data, input bit exp_err);
    do_req(wr, rd, a, d, chk_data, exp_data, exp_err);
    idle();
    drain();
  endtask

  initial begin
    rst_n  = 1'b0;
    Addr   = 32'd0;
    DataIn = 32'd0;
    MemWr  = 1'b0;
    MemRd  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_DataOut", DataOut, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-BUSY discards the pending write.
    single(1'b1, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 32'd0, 1'b0);
    single(1'b0, 1'b1, 32'h10, 32'd0, 1'b1, 32'h1234_5678, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'hBADB_AD00, 1'b0, 32'd0, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_DataOut", DataOut, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    single(1'b0, 1'b1, 32'h10, 32'd0, 1'b1, 32'h1234_5678, 1'b0);

    // Write then read.
    single(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    single(1'b0, 1'b1, 32'h20, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back reads with MemRd held high.
    single(1'b1, 1'b0, 32'h0, 32'hAAAA_0000, 1'b0, 32'd0, 1'b0);
    single(1'b1, 1'b0, 32'h4, 32'hBBBB_0004, 1'b0, 32'd0, 1'b0);
    single(1'b1, 1'b0, 32'h8, 32'hCCCC_0008, 1'b0, 32'd0, 1'b0);
    do_req(1'b0, 1'b1, 32'h0, 32'd0, 1'b1, 32'hAAAA_0000, 1'b0);
    do_req(1'b0, 1'b1, 32'h4, 32'd0, 1'b1, 32'hBBBB_0004, 1'b0);
    do_req(1'b0, 1'b1, 32'h8, 32'd0, 1'b1, 32'hCCCC_0008, 1'b0);
    idle();
    drain();

    // Simultaneous read/write returns the old word.
    single(1'b1, 1'b0, 32'h40, 32'h1111_1111, 1'b0, 32'd0, 1'b0);
    single(1'b1, 1'b1, 32'h40, 32'h2222_2222, 1'b1, 32'h1111_1111, 1'b0);
    single(1'b0, 1'b1, 32'h40, 32'd0, 1'b1, 32'h2222_2222, 1'b0);

    // Address wrap at 4*DEPTH bytes.
    single(1'b1, 1'b0, 32'h400, 32'hA5A5_A5A5, 1'b0, 32'd0, 1'b0);
    single(1'b0, 1'b1, 32'h000, 32'd0, 1'b1, 32'hA5A5_A5A5, 1'b0);

    // Misaligned write.
`ifdef DMEM_ALIGN_CHECK_EN
    single(1'b1, 1'b0, 32'h42, 32'h5, 1'b1, 32'd0, 1'b1);
    single(1'b0, 1'b1, 32'h40, 32'd0, 1'b1, 32'h2222_2222, 1'b0);
`else
    single(1'b1, 1'b0, 32'h42, 32'h5, 1'b0, 32'd0, 1'b0);
    single(1'b0, 1'b1, 32'h40, 32'd0, 1'b1, 32'h5, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
